// File: rtl/uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO onto a serial line.
// Frames are start bit, LSB-first data, optional parity, then one or two stop bits.
module uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 27_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rd_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int unsigned Div  = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);

  localparam logic [CntW-1:0] CntMax   = CntW'(Div - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

  if (Div < 2) begin : gen_div_chk
    $error("uart_tx: bit period must be at least 2 clocks");
  end
  if (PARITY > 2) begin : gen_par_chk
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_stop_chk
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       baud_cnt_q, baud_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_end;

  assign bit_end   = (baud_cnt_q == CntMax);
  // Gate with reset so no pop can leak out while the block is held in reset.
  assign fifo_rd_o = rst_ni && (state_q == StIdle) && !fifo_empty_i;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (fifo_rd_o) begin
          state_d   = StStart;
          shift_d   = fifo_rdata_i;
          par_d     = 1'b0;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          par_d     = par_q ^ shift_q[0];
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
            if (PARITY != 0) begin
              state_d = StPar;
              // par_q already holds the XOR of every data bit sent.
              tx_d    = (PARITY == 1) ? ~par_q : par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            par_d     = par_q ^ shift_q[0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StPar: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == LastStop) begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parity/stop configurations at 4 clocks per bit, each fed by a FIFO
// model and compared every cycle against a frame-level reference of the serial line.
module tb_uart_tx;

  localparam int unsigned Div  = 4;
  localparam int          NDut = 3;

  function automatic int unsigned par_of(int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction

  function automatic int unsigned stop_of(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int unsigned flen(int i);
    return Div * (1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i));
  endfunction

  // Line level of frame bit k for byte b.
  function automatic logic fbit(int i, int unsigned k, logic [7:0] b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && par_of(i) != 0) return (par_of(i) == 2) ? ^b : ~^b;
    return 1'b1;
  endfunction

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NDut-1:0] empty, rd, tx, busy;
  logic [7:0]      rdata [NDut];
  logic [7:0]      mem   [NDut][32];
  int unsigned     wr_ptr[NDut];
  int unsigned     rd_ptr[NDut];
  int unsigned     cyc = 0;

  bit              act [NDut];
  int unsigned     e0  [NDut];
  logic [7:0]      byt [NDut];

  int              n_checks = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : gen_dut
    assign empty[g] = (wr_ptr[g] == rd_ptr[g]);
    assign rdata[g] = mem[g][rd_ptr[g][4:0]];

    uart_tx #(
      .CLK_FREQ_HZ(1_000_000),
      .BAUD       (250_000),
      .DATA_WIDTH (8),
      .PARITY     (par_of(g)),
      .STOP_BITS  (stop_of(g))
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .fifo_empty_i(empty[g]),
      .fifo_rdata_i(rdata[g]),
      .fifo_rd_o   (rd[g]),
      .tx_o        (tx[g]),
      .busy_o      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: once a pop is seen the line follows the frame bits for flen cycles, else idles.
  task automatic mon_cycle();
    for (int i = 0; i < NDut; i++) begin
      logic e_tx, e_busy, e_rd;
      bit   in_f;
      if (!rst_n) begin
        act[i] = 1'b0;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_rd   = 1'b0;
      end else begin
        in_f   = act[i] && (cyc >= e0[i]) && (cyc < e0[i] + flen(i));
        e_tx   = in_f ? fbit(i, (cyc - e0[i]) / Div, byt[i]) : 1'b1;
        e_busy = in_f;
        e_rd   = !in_f && !empty[i];
      end
      check($sformatf("tx[%0d]", i), tx[i], e_tx);
      check($sformatf("busy[%0d]", i), busy[i], e_busy);
      check($sformatf("rd[%0d]", i), rd[i], e_rd);
      if (e_rd) begin
        act[i] = 1'b1;
        e0[i]  = cyc + 1;
        byt[i] = rdata[i];
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon_cycle();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < NDut; i++) if (rd[i] === 1'b1) rd_ptr[i] <= rd_ptr[i] + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_all(input logic [7:0] b);
    for (int i = 0; i < NDut; i++) begin
      mem[i][wr_ptr[i] % 32] = b;
      wr_ptr[i]++;
    end
  endtask

  function automatic int unsigned max_fill();
    int unsigned m = 0;
    for (int i = 0; i < NDut; i++) if (wr_ptr[i] - rd_ptr[i] > m) m = wr_ptr[i] - rd_ptr[i];
    return m;
  endfunction

  task automatic wait_idle();
    for (int n = 0; n < 3000; n++) begin
      if (empty == '1 && busy == '0) return;
      tick(1);
    end
    check("idle_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    push_all(8'hA5);
    tick(10);
    #1 rst_n = 1'b1;
    wait_idle();

    push_all(8'h01);
    wait_idle();

    push_all(8'h00);
    push_all(8'hFF);
    push_all(8'h3C);
    wait_idle();

    // Reset during data bit 3 of 0x55 in the no-parity instance.
    push_all(8'h55);
    push_all(8'h66);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (act[0] && cyc == e0[0] + 4 * Div + 1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("bit3_reach", ok, 1);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDut; i++) begin
      check($sformatf("rst_tx[%0d]", i), tx[i], 1'b1);
      check($sformatf("rst_busy[%0d]", i), busy[i], 1'b0);
      check($sformatf("rst_rd[%0d]", i), rd[i], 1'b0);
    end
    tick(3);
    #1 rst_n = 1'b1;
    wait_idle();

    tick(100);
    push_all(8'h81);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      int unsigned k;
      k = $urandom_range(1, 3);
      for (int j = 0; j < int'(k); j++) if (max_fill() < 14) push_all(8'($urandom));
      tick($urandom_range(1, 60));
    end
    wait_idle();
    tick(5);

    for (int i = 0; i < NDut; i++) check($sformatf("drained[%0d]", i), rd_ptr[i], wr_ptr[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that sits directly downstream of the 16-entry byte FIFO and drains it onto the board TX pin. While the FIFO reports non-empty, the block pops one word, frames it (start bit, LSB-first data, optional parity, stop bits) and shifts it out at a fixed baud rate derived from the system clock. It returns to the FIFO for the next word after each frame, so software-side writers only see FIFO back-pressure.

## Interface
- CLK_FREQ_HZ, 27_000_000: system clock frequency.
- BAUD, 115_200: line rate.
- DATA_WIDTH, 8: data bits per frame; must match the FIFO word width.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- clk_i  in  1  system clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rdata_i  in  DATA_WIDTH  FIFO head word; first-word-fall-through, valid whenever fifo_empty_i = 0.
- fifo_rd_o  out  1  pop strobe to FIFO; one cycle per word.
- tx_o  out  1  serial line; idle high.
- busy_o  out  1  high while a frame is in progress.

## Operation
- Bit period DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD, integer, rounded to nearest. Elaboration fails if DIV < 2, PARITY > 2, or STOP_BITS not in {1,2}. Default DIV = 234.
- Baud counter width $clog2(DIV); counts 0..DIV-1, wraps to 0 at each bit boundary. Bit counter width $clog2(DATA_WIDTH+1).
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: tx_o = 1. If fifo_empty_i = 0, fifo_rd_o = 1 (combinational: IDLE && !fifo_empty_i); on that edge fifo_rdata_i loads the shift register, parity accumulator is cleared, state -> START.
- START: tx_o = 0 for DIV cycles -> DATA.
- DATA: tx_o = shift[0], shift right once per bit period, DATA_WIDTH bit periods -> PAR if PARITY != 0, else STOP.
- PAR: tx_o = XOR of data bits for even, inverted XOR for odd; one bit period -> STOP.
- STOP: tx_o = 1 for STOP_BITS×DIV cycles -> IDLE.
- fifo_rd_o is never asserted outside IDLE, never while fifo_empty_i = 1, never while rst_ni = 0.
- busy_o = (state != IDLE), registered with state.
- Changes on fifo_rdata_i after the pop edge have no effect on the frame in flight.
- Reset (asynchronous, any time including mid-frame): state = IDLE, tx_o = 1, busy_o = 0, counters and shift register = 0, fifo_rd_o = 0. Frame in progress is truncated; no pop occurs on the first rising edge after deassertion unless the IDLE/non-empty condition holds at that edge.

## Timing
- tx_o is a register output; no combinational path from inputs to tx_o.
- Pop at edge E0: tx_o falls at E0 (start bit visible in cycle after E0).
- Frame length F = DIV × (1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS) cycles from E0.
- Back-to-back words: exactly one IDLE cycle after the last stop cycle, so pop-to-pop spacing is F + 1 cycles; that IDLE cycle keeps tx_o high.
- busy_o rises at E0, falls at E0 + F.
- FIFO empty when entering IDLE: block waits indefinitely, tx_o = 1, fifo_rd_o = 0.
- Pop and FIFO write in the same cycle are legal; FIFO owns that ordering.

## Test plan
- Reset values: hold rst_ni = 0, FIFO non-empty -> tx_o = 1, busy_o = 0, fifo_rd_o = 0 throughout.
- Single frame, CLK_FREQ_HZ = 1_000_000, BAUD = 250_000 (DIV = 4), PARITY 0, STOP_BITS 1, push 0xA5 -> one fifo_rd_o pulse; tx_o sequence 0,1,0,1,0,0,1,0,1,1 each held 4 cycles (40 cycles); busy_o high exactly 40 cycles.
- Parity: same config, PARITY = 2 with 0xA5 -> parity bit 0, frame 44 cycles; PARITY = 1 -> parity bit 1; 0x01 with PARITY = 2 -> parity bit 1.
- Back-to-back: push 0x00, 0xFF, 0x3C before start, STOP_BITS = 2 -> three pops spaced 45 cycles apart, exactly one IDLE cycle between frames, bytes decoded in order, FIFO empty after third pop.
- Reset mid-frame: assert rst_ni = 0 during data bit 3 of 0x55 -> tx_o = 1 immediately (before next edge), busy_o = 0; after release with FIFO still holding 0x66, next frame carries 0x66 with full start bit.
- Starvation: FIFO empty 100 cycles, then one push of 0x81 -> no fifo_rd_o during idle; pop occurs on the first edge where fifo_empty_i = 0.
